// File: rtl/fs_accel_pu_ctrl.sv
// Layer sequencer for the 3-PU accelerator array: weight/window fetch, PU firing,
// result handoff and snake-order window sliding for conv layers.
module fs_accel_pu_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             cfg_is_conv,
  input  logic [CNT_W-1:0] cfg_out_w,
  input  logic [CNT_W-1:0] cfg_out_h,
  output logic             fetch_req,
  output logic             fetch_kind,
  output logic [3:0]       fetch_idx,
  input  logic             fetch_ack,
  output logic [8:0]       wreg_enb,
  output logic [2:0]       ireg_enb,
  output logic             pu_enb,
  input  logic             pu_rdy,
  output logic [1:0]       conv_dir,
  output logic             is_conv_layer,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] DIR_NON   = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_ILOAD, S_FIRE, S_WAIT, S_OUT, S_SHIFT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] wlast_q, wlast_d, hlast_q, hlast_d;
  logic             conv_q, conv_d;
  logic [1:0]       dir_q, dir_d;

  // State and layer context registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wlast_q <= '0;
      hlast_q <= '0;
      conv_q  <= 1'b0;
      dir_q   <= DIR_NON;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wlast_q <= wlast_d;
      hlast_q <= hlast_d;
      conv_q  <= conv_d;
      dir_q   <= dir_d;
    end
  end

  // Next state, counters and handshake outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    wlast_d    = wlast_q;
    hlast_d    = hlast_q;
    conv_d     = conv_q;
    dir_d      = dir_q;
    fetch_req  = 1'b0;
    fetch_kind = 1'b0;
    fetch_idx  = 4'd0;
    wreg_enb   = 9'd0;
    ireg_enb   = 3'd0;
    pu_enb     = 1'b0;
    conv_dir   = DIR_NON;
    out_vld    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WLOAD;
          conv_d  = cfg_is_conv;
          // A zero dimension behaves as one, so store last index directly
          wlast_d = (cfg_out_w == '0) ? '0 : cfg_out_w - CNT_W'(1);
          hlast_d = (cfg_out_h == '0) ? '0 : cfg_out_h - CNT_W'(1);
          col_d   = '0;
          row_d   = '0;
          idx_d   = 4'd0;
          dir_d   = DIR_NON;
        end
      end
      S_WLOAD: begin
        fetch_req = 1'b1;
        fetch_idx = idx_q;
        if (fetch_ack) begin
          wreg_enb = 9'd1 << idx_q;
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = S_ILOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ILOAD: begin
        fetch_req  = 1'b1;
        fetch_kind = 1'b1;
        fetch_idx  = idx_q;
        if (fetch_ack) begin
          ireg_enb = 3'd1 << idx_q[1:0];
          if (idx_q == 4'd2) begin
            idx_d   = 4'd0;
            state_d = S_FIRE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_FIRE: begin
        pu_enb  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pu_rdy) state_d = S_OUT;
      end
      S_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          if (col_q == wlast_q && (!conv_q || row_q == hlast_q)) begin
            state_d = S_DONE;
          end else if (!conv_q) begin
            col_d   = col_q + CNT_W'(1);
            state_d = S_ILOAD;
          end else if (col_q != wlast_q) begin
            col_d   = col_q + CNT_W'(1);
            dir_d   = row_q[0] ? DIR_LEFT : DIR_RIGHT;
            state_d = S_SHIFT;
          end else begin
            row_d   = row_q + CNT_W'(1);
            col_d   = '0;
            dir_d   = DIR_DOWN;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        fetch_req  = 1'b1;
        fetch_kind = 1'b1;
        conv_dir   = dir_q;
        if (fetch_ack) begin
          ireg_enb = 3'b111;
          state_d  = S_FIRE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign is_conv_layer = conv_q;

endmodule
